alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_if.sv | 25 ++
 rtl/alu_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Operand/control bus and status bundle for alu_seq.
// The tri-state result stays a plain module port because it is shared with external bus drivers.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] bus_in;
    logic             load_a;
    logic             load_b;
    logic [3:0]       func_sel;
    logic             start;
    logic             out_en;
    logic [3:0]       flags;
    logic             busy;
    logic             done;

    modport slave (
        input  bus_in, load_a, load_b, func_sel, start, out_en,
        output flags, busy, done
    );

    modport master (
        output bus_in, load_a, load_b, func_sel, start, out_en,
        input  flags, busy, done
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU with operand registers A/B and result register R.
// Provides a {V,C,N,Z} flag register and an optional WIDTH-cycle shift-add multiplier.
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             async_reset,
    alu_seq_if.slave         bus,
    output tri   [WIDTH-1:0] result
);
    localparam int MSB   = WIDTH - 1;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {IDLE, MUL} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, r_q, r_d;
    logic [WIDTH-1:0]     ma_q, ma_d, mb_q, mb_d;
    logic [3:0]           flags_q, flags_d;
    logic                 hi_q, hi_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 done_q, done_d;

    logic [WIDTH:0]       ext;
    logic [WIDTH-1:0]     alu_r;
    logic                 alu_c, alu_v, c_in;
    logic [2*WIDTH-1:0]   partial, prod;
    logic [WIDTH-1:0]     mul_r;
    logic                 is_mul;

    // Single-cycle datapath; C input only matters for adc/sbc (func_sel[3]=1)
    always_comb begin
        ext   = '0;
        alu_r = '0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        c_in  = bus.func_sel[3] & flags_q[2];
        case (bus.func_sel)
            4'b0001, 4'b1001: begin
                ext   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, c_in};
                alu_r = ext[MSB:0];
                alu_c = ext[WIDTH];
                alu_v = (a_q[MSB] == b_q[MSB]) && (alu_r[MSB] != a_q[MSB]);
            end
            4'b0010, 4'b1010: begin
                ext   = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, c_in};
                alu_r = ext[MSB:0];
                alu_c = ext[WIDTH];
                alu_v = (a_q[MSB] != b_q[MSB]) && (alu_r[MSB] != a_q[MSB]);
            end
            4'b0011: alu_r = a_q ^ b_q;
            4'b0100: alu_r = a_q & b_q;
            4'b0101: alu_r = a_q | b_q;
            4'b0110: begin
                alu_r = {a_q[MSB-1:0], 1'b0};
                alu_c = a_q[MSB];
            end
            4'b0111: begin
                alu_r = {1'b0, a_q[MSB:1]};
                alu_c = a_q[0];
            end
            default: alu_r = '0;
        endcase
    end

    // Shift-add step: the final partial product is folded in combinationally on the last edge
    always_comb begin
        partial = mb_q[cnt_q] ? ({{WIDTH{1'b0}}, ma_q} << cnt_q) : '0;
        prod    = acc_q + partial;
        mul_r   = hi_q ? prod[2*WIDTH-1:WIDTH] : prod[MSB:0];
    end

    assign is_mul = (bus.func_sel[3:1] == 3'b110) && (MUL_EN != 0);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        flags_d = flags_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        done_d  = 1'b0;

        if (bus.load_a) a_d = bus.bus_in;
        if (bus.load_b) b_d = bus.bus_in;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (is_mul) begin
                        state_d = MUL;
                        ma_d    = a_q;
                        mb_d    = b_q;
                        hi_d    = bus.func_sel[0];
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else begin
                        r_d     = alu_r;
                        flags_d = {alu_v, alu_c, alu_r[MSB], alu_r == '0};
                        done_d  = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d = prod;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = IDLE;
                    r_d     = mul_r;
                    flags_d = {2'b00, mul_r[MSB], mul_r == '0};
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            flags_q <= '0;
            hi_q    <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            flags_q <= flags_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
        end
    end

    assign bus.flags = flags_q;
    assign bus.busy  = (state_q == MUL);
    assign bus.done  = done_q;
    assign result    = bus.out_en ? r_q : 'z;
endmodule
